// File: rtl/gost_round_sequencer.sv
// gost_round_sequencer
// Iterative controller for the 64-bit GOST 28147-89 Feistel cipher. It holds
// the L/R halves, the latched 256-bit key, the direction and the round index.
// It drives an external combinational round function f(R,K) once per clock.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     host handshake for {in_message, in_key, in_decrypt}
//   out_valid/out_ready   result handshake, out_data = {R_final, L_final}
//   abort                 synchronous cancel of the block in flight
//   rf_data_o/rf_key_o    current R and subkey to the round unit (0 when idle)
//   rf_round_o            current round index (0 when idle)
//   rf_result_i           f(R,K), returned in the same cycle
//   busy                  high while rounds are executing
//
// state  | meaning
// IDLE   | waiting for a block, in_ready high
// ROUND  | one Feistel round per clock, busy high
// DONE   | result held on out_data until the consumer takes it
module gost_round_sequencer #(
  parameter int ROUNDS = 32,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_decrypt,
  input  logic [63:0]      in_message,
  input  logic [255:0]     in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  input  logic             abort,
  output logic [31:0]      rf_data_o,
  output logic [31:0]      rf_key_o,
  output logic [CNT_W-1:0] rf_round_o,
  input  logic [31:0]      rf_result_i,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);
  localparam int ENC_FWD_ROUNDS = ROUNDS - 8;

  logic [1:0]       state;
  logic [CNT_W-1:0] round_q;
  logic [31:0]      l_q;
  logic [31:0]      r_q;
  logic [255:0]     key_q;
  logic             decrypt_q;
  logic [63:0]      out_data_q;

  logic [31:0]      key_w [8];
  logic             fwd_order;
  logic [2:0]       key_idx;
  logic [31:0]      r_next;

  for (genvar j = 0; j < 8; j++) begin : g_key_words
    assign key_w[j] = key_q[255 - 32*j -: 32];
  end

  // Encrypt walks k0..k7 until the last 8 rounds, which run k7..k0.
  // Decrypt is the exact reverse: k0..k7 once, then k7..k0 for the rest.
  always_comb begin
    fwd_order = 1'b0;
    if (decrypt_q) begin
      fwd_order = (int'(round_q) < 8);
    end else begin
      fwd_order = (int'(round_q) < ENC_FWD_ROUNDS);
    end
    key_idx = fwd_order ? round_q[2:0] : ~round_q[2:0];
  end

  assign r_next     = l_q ^ rf_result_i;
  assign busy       = (state == S_ROUND);
  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign out_data   = out_data_q;
  assign rf_data_o  = busy ? r_q : '0;
  assign rf_key_o   = busy ? key_w[key_idx] : '0;
  assign rf_round_o = busy ? round_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      round_q    <= '0;
      l_q        <= '0;
      r_q        <= '0;
      key_q      <= '0;
      decrypt_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // abort has no meaning here; a valid block is always taken
          if (in_valid) begin
            l_q       <= in_message[63:32];
            r_q       <= in_message[31:0];
            key_q     <= in_key;
            decrypt_q <= in_decrypt;
            round_q   <= '0;
            state     <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (abort) begin
            round_q <= '0;
            state   <= S_IDLE;
          end else begin
            l_q <= r_q;
            r_q <= r_next;
            if (round_q == LAST_ROUND) begin
              // output order undoes the swap of the final round
              out_data_q <= {r_next, r_q};
              round_q    <= '0;
              state      <= S_DONE;
            end else begin
              round_q <= round_q + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          if (abort || out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gost_round_sequencer.sv
module tb_gost_round_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_decrypt;
  logic [63:0]  in_message;
  logic [255:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         abort;
  logic [31:0]  rf_data_o;
  logic [31:0]  rf_key_o;
  logic [4:0]   rf_round_o;
  logic [31:0]  rf_result_i;
  logic         busy;
  logic         use_f;

  int n_checks = 0;
  int n_fail   = 0;

  gost_round_sequencer #(.ROUNDS(32), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_decrypt  (in_decrypt),
    .in_message  (in_message),
    .in_key      (in_key),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .abort       (abort),
    .rf_data_o   (rf_data_o),
    .rf_key_o    (rf_key_o),
    .rf_round_o  (rf_round_o),
    .rf_result_i (rf_result_i),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // S-box rows, nibble v of row i at bits [4v+3:4v]
  localparam logic [63:0] SBOX [8] = '{
    64'h4A92D80E6B1C7F53, 64'hEB4C6DFA27810953,
    64'h581DA342EFC7609B, 64'h7DA1089FE46CB253,
    64'h6C715FD84A9E03B2, 64'h4BA0721D36859CFE,
    64'hDB413F590AE7C286, 64'h1FD057A4923E6B8C
  };

  localparam logic [255:0] KEY_A = {
    32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
    32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888
  };
  localparam logic [255:0] KEY_B = {
    32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210,
    32'hA5A5A5A5, 32'h5A5A5A5A, 32'hDEADBEEF, 32'hCAFEBABE
  };

  function automatic logic [31:0] gost_f(input logic [31:0] r, input logic [31:0] k);
    logic [31:0] s;
    logic [31:0] t;
    logic [63:0] row;
    int          sh;
    s = r + k;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      row = SBOX[i];
      sh  = 4 * int'(s[4*i +: 4]);
      t[4*i +: 4] = row[sh +: 4];
    end
    return {t[20:0], t[31:11]};
  endfunction

  function automatic int exp_idx(input int rnd, input bit dec);
    if (dec) return (rnd < 8) ? rnd : 7 - (rnd % 8);
    return (rnd < 24) ? (rnd % 8) : 7 - (rnd % 8);
  endfunction

  function automatic logic [63:0] gost_ref(input logic [63:0] msg, input logic [255:0] key, input bit dec);
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] t;
    int          idx;
    l = msg[63:32];
    r = msg[31:0];
    for (int rnd = 0; rnd < 32; rnd++) begin
      idx = exp_idx(rnd, dec);
      t = l ^ gost_f(r, key[255 - 32*idx -: 32]);
      l = r;
      r = t;
    end
    return {r, l};
  endfunction

  always_comb begin
    rf_result_i = '0;
    if (use_f) rf_result_i = gost_f(rf_data_o, rf_key_o);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic start_block(input logic [63:0] msg, input logic [255:0] key,
                             input bit dec, input bit acc_abort);
    in_valid   = 1'b1;
    in_message = msg;
    in_key     = key;
    in_decrypt = dec;
    abort      = acc_abort;
    check_eq("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid   = 1'b0;
    abort      = 1'b0;
    in_message = ~msg;
    in_key     = ~key;
    in_decrypt = ~dec;
  endtask

  task automatic run_block(input logic [63:0] msg, input logic [255:0] key, input bit dec,
                           input bit chk_keys, input bit acc_abort, output logic [63:0] res);
    int lat;
    start_block(msg, key, dec, acc_abort);
    check_eq("rf_data_round0", 64'(rf_data_o), 64'(msg[31:0]));
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (chk_keys) begin
        check_eq($sformatf("busy_r%0d", lat), 64'(busy), 64'd1);
        check_eq($sformatf("in_ready_r%0d", lat), 64'(in_ready), 64'd0);
        check_eq($sformatf("rf_round_r%0d", lat), 64'(rf_round_o), 64'(lat));
        check_eq($sformatf("rf_key_r%0d", lat), 64'(rf_key_o),
                 64'(32'h11111111 * (exp_idx(lat, dec) + 1)));
      end
      lat++;
      @(negedge clk);
    end
    check_eq("latency", 64'(lat), 64'd32);
    check_eq("busy_done", 64'(busy), 64'd0);
    check_eq("rf_key_done", 64'(rf_key_o), 64'd0);
    res = out_data;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("out_valid_after_xfer", 64'(out_valid), 64'd0);
    check_eq("in_ready_after_xfer", 64'(in_ready), 64'd1);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_rf_round"}, 64'(rf_round_o), 64'd0);
    check_eq({tag, "_rf_data"}, 64'(rf_data_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] res;
    logic [63:0] ct;
    int          w;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_decrypt = 1'b0;
    in_message = '0;
    in_key     = '0;
    out_ready  = 1'b0;
    abort      = 1'b0;
    use_f      = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check_eq("reset_out_data", out_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // f = 0, encrypt: halves swap 32 times, output order undoes the last swap
    run_block(64'h0123456789ABCDEF, KEY_A, 1'b0, 1'b1, 1'b0, res);
    check_eq("enc_f0_data", res, 64'h89ABCDEF01234567);
    take_result();

    // f = 0, decrypt schedule
    run_block(64'hDEADBEEFCAFEF00D, KEY_A, 1'b1, 1'b1, 1'b0, res);
    check_eq("dec_f0_data", res, 64'hCAFEF00DDEADBEEF);
    take_result();

    // real round function, round trip with backpressure on the encrypt result
    use_f = 1'b1;
    run_block(64'hFEDCBA9876543210, KEY_B, 1'b0, 1'b0, 1'b0, ct);
    check_eq("enc_f_model", ct, gost_ref(64'hFEDCBA9876543210, KEY_B, 1'b0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq($sformatf("bp_out_data_%0d", i), out_data, ct);
      check_eq($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 64'd0);
      check_eq($sformatf("bp_out_valid_%0d", i), 64'(out_valid), 64'd1);
    end
    take_result();
    run_block(ct, KEY_B, 1'b1, 1'b0, 1'b0, res);
    check_eq("dec_roundtrip", res, 64'hFEDCBA9876543210);
    take_result();

    // abort at round 10
    start_block(64'h0011223344556677, KEY_B, 1'b0, 1'b0);
    w = 0;
    while (rf_round_o != 5'd10 && w < 40) begin
      w++;
      @(negedge clk);
    end
    check_eq("abort_reach_r10", 64'(rf_round_o), 64'd10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("after_abort");
    @(negedge clk);
    check_idle("after_abort_hold");
    run_block(64'h0011223344556677, KEY_B, 1'b0, 1'b0, 1'b0, res);
    check_eq("post_abort_data", res, gost_ref(64'h0011223344556677, KEY_B, 1'b0));
    take_result();

    // reset pulsed mid-block
    start_block(64'h8899AABBCCDDEEFF, KEY_A, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    check_eq("async_reset_out_data", out_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // abort asserted with in_valid in IDLE: block is still accepted
    run_block(64'h8899AABBCCDDEEFF, KEY_A, 1'b1, 1'b0, 1'b1, res);
    check_eq("post_reset_data", res, gost_ref(64'h8899AABBCCDDEEFF, KEY_A, 1'b1));
    take_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
